// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: default widths, memory depth and the
// memory-port sequencer state encoding used by the master, MainMemory and control unit.
package cpu_bus_pkg;

  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_MEM_DEPTH = 16384;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } bus_state_t;

endpackage

// File: rtl/mem_bus_master.sv
// mem_bus_master: single-outstanding load/store initiator (MAR/MBR sequencer) for MainMemory.
// Optional MEM_BUS_BOUNDS_CHECK_EN rejects addresses >= MEM_DEPTH with rsp_err instead of issuing them.
module mem_bus_master
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  bus_state_t state;
  logic       we_q;
  logic       reject;

`ifdef MEM_BUS_BOUNDS_CHECK_EN
  assign reject = (64'(req_addr) >= 64'(MEM_DEPTH));
`else
  assign reject  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Rejected requests skip the memory entirely so mem_addr/mem_we keep their idle values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      we_q      <= 1'b0;
`ifdef MEM_BUS_BOUNDS_CHECK_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef MEM_BUS_BOUNDS_CHECK_EN
            rsp_err   <= reject;
`endif
            if (reject) begin
              rsp_rdata <= '0;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              mem_addr  <= req_addr;
              mem_wdata <= req_wdata;
              mem_we    <= req_we;
              we_q      <= req_we;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          mem_we <= 1'b0;
          if (we_q) begin
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          rsp_rdata <= mem_rdata;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
